// File: rtl/preg_alloc_sched.sv
// Physical register allocation scheduler: prefetches free tags into a small FIFO
// for a two-wide rename stage and serialises commit-side releases back to the free list.
module preg_alloc_sched #(
  parameter int PREG_W    = 6,
  parameter int PF_DEPTH  = 4,
  parameter int REL_DEPTH = 4,
  parameter int BACKOFF   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      fl_alloc_en,
  input  logic [PREG_W-1:0]         fl_alloc_phys,
  input  logic                      fl_alloc_valid,
  output logic                      fl_free_en,
  output logic [PREG_W-1:0]         fl_free_phys,
  input  logic [1:0]                ren_req,
  output logic [1:0]                ren_grant,
  output logic [PREG_W-1:0]         ren_phys0,
  output logic [PREG_W-1:0]         ren_phys1,
  input  logic [1:0]                rel_en,
  input  logic [PREG_W-1:0]         rel_phys0,
  input  logic [PREG_W-1:0]         rel_phys1,
  output logic                      rel_ready,
  output logic [$clog2(PF_DEPTH):0] pf_count
);

  localparam int PF_AW  = $clog2(PF_DEPTH);
  localparam int PF_CW  = PF_AW + 1;
  localparam int REL_AW = $clog2(REL_DEPTH);
  localparam int REL_CW = REL_AW + 1;
  localparam int BO_W   = (BACKOFF < 1) ? 1 : $clog2(BACKOFF + 1);

  localparam logic [BO_W-1:0] BO_LOAD = BO_W'(BACKOFF);

  typedef enum logic {
    FETCH,
    EMPTY_WAIT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BO_W-1:0]   r_backoff;
  logic [BO_W-1:0]   w_backoff_nxt;
  logic              r_inflight;

  logic [PREG_W-1:0] r_pf_mem [PF_DEPTH];
  logic [PF_AW-1:0]  r_pf_rd;
  logic [PF_AW-1:0]  r_pf_wr;
  logic [PF_CW-1:0]  r_pf_count;

  logic [PREG_W-1:0] r_rel_mem [REL_DEPTH];
  logic [REL_AW-1:0] r_rel_rd;
  logic [REL_AW-1:0] r_rel_wr;
  logic [REL_CW-1:0] r_rel_count;
  logic              r_free_en;
  logic [PREG_W-1:0] r_free_phys;

  logic [PF_CW:0]    w_pf_plus_inflight;
  logic              w_alloc_en;
  logic              w_rsp_ok;
  logic              w_rsp_fail;
  logic [1:0]        w_grant;
  logic [1:0]        w_pf_pop_n;
  logic              w_pf_push;
  logic [PF_AW-1:0]  w_pf_rd_p1;
  logic              w_rel_ready;
  logic              w_rel_push0;
  logic              w_rel_push1;
  logic [1:0]        w_rel_push_n;
  logic [REL_AW-1:0] w_rel_wr1;
  logic              w_rel_pop;

  // Pops are deliberately not credited so the request decision depends only on flops.
  assign w_pf_plus_inflight = {1'b0, r_pf_count} + {{PF_CW{1'b0}}, r_inflight};
  assign w_alloc_en = !reset && (r_state == FETCH) &&
                      (w_pf_plus_inflight < (PF_CW + 1)'(PF_DEPTH));

  assign w_rsp_ok   = r_inflight && fl_alloc_valid;
  assign w_rsp_fail = r_inflight && !fl_alloc_valid;

  assign w_grant[0] = ren_req[0] && (r_pf_count >= PF_CW'(1));
  assign w_grant[1] = ren_req[1] && ren_req[0] && (r_pf_count >= PF_CW'(2));
  assign w_pf_pop_n = {w_grant[1], w_grant[0] & ~w_grant[1]};
  assign w_pf_push  = !reset && w_rsp_ok &&
                      ((r_pf_count < PF_CW'(PF_DEPTH)) || w_grant[0]);
  assign w_pf_rd_p1 = r_pf_rd + PF_AW'(1);

  assign w_rel_ready  = (r_rel_count <= REL_CW'(REL_DEPTH - 2));
  assign w_rel_push0  = !reset && rel_en[0] && w_rel_ready;
  assign w_rel_push1  = !reset && rel_en[1] && w_rel_ready;
  assign w_rel_push_n = {1'b0, w_rel_push0} + {1'b0, w_rel_push1};
  assign w_rel_wr1    = r_rel_wr + REL_AW'(w_rel_push0);
  assign w_rel_pop    = (r_rel_count != '0);

  assign fl_alloc_en  = w_alloc_en;
  assign fl_free_en   = r_free_en;
  assign fl_free_phys = r_free_phys;
  assign ren_grant    = w_grant;
  assign ren_phys0    = r_pf_mem[r_pf_rd];
  assign ren_phys1    = r_pf_mem[w_pf_rd_p1];
  assign rel_ready    = w_rel_ready;
  assign pf_count     = r_pf_count;

  // A failed response always (re)arms the backoff, even if a release arrives alongside it.
  always_comb begin
    w_state_nxt   = r_state;
    w_backoff_nxt = r_backoff;
    case (r_state)
      FETCH: begin
        if (w_rsp_fail) begin
          w_state_nxt   = EMPTY_WAIT;
          w_backoff_nxt = BO_LOAD;
        end
      end
      EMPTY_WAIT: begin
        if (w_rsp_fail) begin
          w_backoff_nxt = BO_LOAD;
        end else if (r_free_en || (r_backoff <= BO_W'(1))) begin
          w_state_nxt   = FETCH;
          w_backoff_nxt = '0;
        end else begin
          w_backoff_nxt = r_backoff - BO_W'(1);
        end
      end
      default: begin
        w_state_nxt   = FETCH;
        w_backoff_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FETCH;
      r_backoff  <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_backoff  <= w_backoff_nxt;
      r_inflight <= w_alloc_en;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pf_rd    <= '0;
      r_pf_wr    <= '0;
      r_pf_count <= '0;
    end else begin
      if (w_pf_push) begin
        r_pf_wr <= r_pf_wr + PF_AW'(1);
      end
      r_pf_rd    <= r_pf_rd + PF_AW'(w_pf_pop_n);
      r_pf_count <= r_pf_count + PF_CW'(w_pf_push) - PF_CW'(w_pf_pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (w_pf_push) begin
      r_pf_mem[r_pf_wr] <= fl_alloc_phys;
    end
  end

  // The older release lands first so tags drain back in commit order.
  always_ff @(posedge clk) begin
    if (w_rel_push0) begin
      r_rel_mem[r_rel_wr] <= rel_phys0;
    end
    if (w_rel_push1) begin
      r_rel_mem[w_rel_wr1] <= rel_phys1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rel_rd    <= '0;
      r_rel_wr    <= '0;
      r_rel_count <= '0;
      r_free_en   <= 1'b0;
      r_free_phys <= '0;
    end else begin
      r_rel_wr    <= r_rel_wr + REL_AW'(w_rel_push_n);
      r_rel_count <= r_rel_count + REL_CW'(w_rel_push_n) - REL_CW'(w_rel_pop);
      r_free_en   <= w_rel_pop;
      if (w_rel_pop) begin
        r_rel_rd    <= r_rel_rd + REL_AW'(1);
        r_free_phys <= r_rel_mem[r_rel_rd];
      end
    end
  end

  a_rel_overflow: assert property (@(posedge clk) disable iff (reset)
    !((|rel_en) && !w_rel_ready));

endmodule
